// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_pkg
//  Purpose  : Shared definitions for the program loader: FSM state encoding,
//             the default header sync nibble and header field positions.
//  Revision : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Loader FSM states. FILL is only reachable when LOADER_ZERO_FILL_EN
    // is defined at build time.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_FILL = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    // Default value of the header's upper nibble that marks a frame start.
    localparam logic [3:0] c_SYNC_NIBBLE = 4'hA;

    // Header byte layout: [7:4] sync nibble, [ADDRESS_WIDTH-1:0] word count - 1.
    localparam int c_HDR_SYNC_MSB = 7;
    localparam int c_HDR_SYNC_LSB = 4;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Byte-stream program loader. Receives a framed image
//             (header, N data bytes, checksum) on a valid/ready byte port,
//             writes it into program RAM while holding the CPU, verifies the
//             8-bit wrapping checksum and releases the CPU with a start pulse.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk          : system clock, posedge
//    rst          : synchronous active-high reset
//    in_data      : incoming byte
//    in_valid     : in_data valid
//    in_ready     : loader can accept a byte (transfer on valid && ready)
//    mem_we       : RAM write strobe, one cycle per word
//    mem_addr     : RAM write address
//    mem_data     : RAM write data
//    cpu_hold     : holds the CPU halted while high
//    cpu_start    : one-cycle pulse when a good image is released
//    busy         : load in progress (DATA/CSUM/FILL)
//    err          : sticky checksum error, cleared by the next accepted header
//    loaded_count : word count of the last good image
//
//  Build option
//    LOADER_ZERO_FILL_EN : when defined, words N..2**ADDRESS_WIDTH-1 are
//                          written with zero after a good checksum, before
//                          the CPU is released.
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         WIDTH         = 8,
    parameter int         ADDRESS_WIDTH = 4,
    parameter logic [3:0] SYNC_NIBBLE   = c_SYNC_NIBBLE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_data,
    output logic                     cpu_hold,
    output logic                     cpu_start,
    output logic                     busy,
    output logic                     err,
    output logic [ADDRESS_WIDTH:0]   loaded_count
);

    state_t                   r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_last,  w_last_nxt;   // index of the last data word (N-1)
    logic [ADDRESS_WIDTH-1:0] r_addr,  w_addr_nxt;
    logic [WIDTH-1:0]         r_acc,   w_acc_nxt;
    logic                     r_in_ready;
    logic                     r_mem_we,       w_mem_we_nxt;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr,     w_mem_addr_nxt;
    logic [WIDTH-1:0]         r_mem_data,     w_mem_data_nxt;
    logic                     r_cpu_hold,     w_cpu_hold_nxt;
    logic                     r_cpu_start,    w_cpu_start_nxt;
    logic                     r_busy;
    logic                     r_err,          w_err_nxt;
    logic [ADDRESS_WIDTH:0]   r_loaded_count, w_loaded_count_nxt;

    logic                     w_xfer;
    logic                     w_is_sync;
    logic [WIDTH-1:0]         w_sum;
    logic                     w_release;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_is_sync = (in_data[c_HDR_SYNC_MSB:c_HDR_SYNC_LSB] == SYNC_NIBBLE);
    assign w_sum     = r_acc + in_data;

    always_comb begin
        w_state_nxt        = r_state;
        w_last_nxt         = r_last;
        w_addr_nxt         = r_addr;
        w_acc_nxt          = r_acc;
        w_mem_we_nxt       = 1'b0;
        w_mem_addr_nxt     = r_mem_addr;
        w_mem_data_nxt     = r_mem_data;
        w_cpu_hold_nxt     = r_cpu_hold;
        w_cpu_start_nxt    = 1'b0;
        w_err_nxt          = r_err;
        w_loaded_count_nxt = r_loaded_count;
        w_release          = 1'b0;

        case (r_state)
            // A header accepted while the CPU runs re-arms the hold and
            // starts a fresh load, exactly as from IDLE.
            ST_IDLE, ST_RUN: begin
                if (w_xfer && w_is_sync) begin
                    w_last_nxt     = in_data[ADDRESS_WIDTH-1:0];
                    w_acc_nxt      = in_data;
                    w_addr_nxt     = '0;
                    w_err_nxt      = 1'b0;
                    w_cpu_hold_nxt = 1'b1;
                    w_state_nxt    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_mem_we_nxt   = 1'b1;
                    w_mem_addr_nxt = r_addr;
                    w_mem_data_nxt = in_data;
                    w_acc_nxt      = w_sum;
                    // After the last word this leaves r_addr at N, which is
                    // where zero fill starts (wraps to 0 only when N is full).
                    w_addr_nxt     = r_addr + ADDRESS_WIDTH'(1);
                    if (r_addr == r_last) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    if (w_sum == '0) begin
`ifdef LOADER_ZERO_FILL_EN
                        if (r_last == {ADDRESS_WIDTH{1'b1}}) begin
                            w_release = 1'b1;
                        end else begin
                            w_state_nxt = ST_FILL;
                        end
`else
                        w_release = 1'b1;
`endif
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            ST_FILL: begin
                w_mem_we_nxt   = 1'b1;
                w_mem_addr_nxt = r_addr;
                w_mem_data_nxt = '0;
                w_addr_nxt     = r_addr + ADDRESS_WIDTH'(1);
                if (r_addr == {ADDRESS_WIDTH{1'b1}}) begin
                    w_release = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_release) begin
            w_state_nxt        = ST_RUN;
            w_cpu_hold_nxt     = 1'b0;
            w_cpu_start_nxt    = 1'b1;
            w_loaded_count_nxt = {1'b0, r_last} + (ADDRESS_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last         <= '0;
            r_addr         <= '0;
            r_acc          <= '0;
            r_in_ready     <= 1'b1;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_cpu_hold     <= 1'b1;
            r_cpu_start    <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_loaded_count <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_last         <= w_last_nxt;
            r_addr         <= w_addr_nxt;
            r_acc          <= w_acc_nxt;
            r_in_ready     <= (w_state_nxt != ST_FILL);
            r_mem_we       <= w_mem_we_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_mem_data     <= w_mem_data_nxt;
            r_cpu_hold     <= w_cpu_hold_nxt;
            r_cpu_start    <= w_cpu_start_nxt;
            r_busy         <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_CSUM) ||
                              (w_state_nxt == ST_FILL);
            r_err          <= w_err_nxt;
            r_loaded_count <= w_loaded_count_nxt;
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign cpu_hold     = r_cpu_hold;
    assign cpu_start    = r_cpu_start;
    assign busy         = r_busy;
    assign err          = r_err;
    assign loaded_count = r_loaded_count;

endmodule
`default_nettype wire
